// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: register map, status bit
// positions and the transmit FSM encoding.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int unsigned STATUS_W        = 4;
  localparam int unsigned ST_TX_NOT_FULL  = 0;
  localparam int unsigned ST_RX_NOT_EMPTY = 1;
  localparam int unsigned ST_RX_OVERRUN   = 2;
  localparam int unsigned ST_TX_EMPTY     = 3;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spart_bus_ctrl_if.sv
// Processor-side register bus of the SPART: chip select, direction, address
// and the two data paths.
interface spart_bus_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              iocs;
  logic              iorw;
  logic [1:0]        ioaddr;
  logic [DATA_W-1:0] databus_in;
  logic [DATA_W-1:0] databus_out;

  modport master (
    output iocs, iorw, ioaddr, databus_in,
    input  databus_out
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus_in,
    output databus_out
  );

endinterface

// File: rtl/spart_fifo.sv
// Power-of-two synchronous FIFO with a combinational head; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module spart_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus controller: register decode, RX/TX FIFOs, baud divisor registers
// and the transmit launch FSM.
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned         DATA_W     = 8,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [2*DATA_W-1:0] DIV_RESET  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spart_bus_ctrl_if.slave       bus,
  input  logic                  rx_valid,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [DATA_W-1:0]     tx_data,
  output logic [2*DATA_W-1:0]   divisor_out,
  output logic                  divisor_wr
);

  logic              wr_c;
  logic              rd_c;
  logic              rx_pop;
  logic              tx_push;
  logic              tx_pop;
  logic              overrun_set;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_full;
  logic              tx_empty_fifo;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] tx_head;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] staging;
  logic [STATUS_W-1:0] status;
  logic              rx_overrun;
  tx_state_e         state;

  assign wr_c        = bus.iocs && !bus.iorw;
  assign rd_c        = bus.iocs &&  bus.iorw;
  assign rx_pop      = rd_c && (bus.ioaddr == ADDR_DATA) && !rx_empty;
  assign tx_push     = wr_c && (bus.ioaddr == ADDR_DATA);
  assign tx_pop      = (state == TX_IDLE) && !tx_empty_fifo && tx_ready;
  assign overrun_set = rx_valid && rx_full && !rx_pop;

  spart_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  spart_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.databus_in),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty_fifo)
  );

  always_comb begin
    status                  = '0;
    status[ST_TX_NOT_FULL]  = !tx_full;
    status[ST_RX_NOT_EMPTY] = !rx_empty;
    status[ST_RX_OVERRUN]   = rx_overrun;
    status[ST_TX_EMPTY]     = tx_empty_fifo && (state == TX_IDLE);
  end

  // Read mux; divisor addresses read back as zero.
  always_comb begin
    rd_data = '0;
    if (rd_c) begin
      case (bus.ioaddr)
        ADDR_DATA:   rd_data = rx_empty ? '0 : rx_head;
        ADDR_STATUS: rd_data = DATA_W'(status);
        default:     rd_data = '0;
      endcase
    end
  end

  assign bus.databus_out = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun  <= 1'b0;
      staging     <= '0;
      divisor_out <= DIV_RESET;
      divisor_wr  <= 1'b0;
    end else begin
      divisor_wr <= 1'b0;
      if (overrun_set) begin
        rx_overrun <= 1'b1;
      end else if (wr_c && (bus.ioaddr == ADDR_STATUS)) begin
        rx_overrun <= 1'b0;
      end
      if (wr_c && (bus.ioaddr == ADDR_DIV_LO)) begin
        staging <= bus.databus_in;
      end
      if (wr_c && (bus.ioaddr == ADDR_DIV_HI)) begin
        divisor_out <= {bus.databus_in, staging};
        divisor_wr  <= 1'b1;
      end
    end
  end

  // WAIT ignores tx_ready while the strobe is still high, since the
  // transmitter only drops tx_ready in the cycle after it samples tx_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_data <= tx_head;
            state   <= TX_LAUNCH;
          end
        end
        TX_LAUNCH: begin
          tx_start <= 1'b1;
          state    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_ready && !tx_start) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed self-checking bench for spart_bus_ctrl (DATA_W=8, FIFO_DEPTH=4).
module tb_spart_bus_ctrl;
  import spart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] divisor_out;
  logic        divisor_wr;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int base;
  logic [7:0] tx_log [0:63];
  logic [7:0] d;

  spart_bus_ctrl_if #(.DATA_W(8)) bus ();

  spart_bus_ctrl #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'h00A5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .divisor_out (divisor_out),
    .divisor_wr  (divisor_wr)
  );

  always #5 clk = ~clk;

  // Record every launch strobe and the character it carries.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_log[tx_cnt[5:0]] = tx_data;
      tx_cnt = tx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; bus.databus_in = v;
    @(negedge clk);
    bus.iocs = 1'b0; bus.databus_in = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #1 v = bus.databus_out;
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_read(a, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic rx_push(input logic [7:0] v);
    rx_valid = 1'b1; rx_data = v;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; bus.databus_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_divisor", 32'(divisor_out), 32'h00A5);
    check("rst_divisor_wr", 32'(divisor_wr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_read("rst_status", ADDR_STATUS, 8'h09);

    // Divisor: low write alone is invisible, high write commits both bytes.
    bus_write(ADDR_DIV_LO, 8'h34);
    check("div_lo_no_change", 32'(divisor_out), 32'h00A5);
    check("div_lo_no_strobe", 32'(divisor_wr), 32'h0);
    bus_write(ADDR_DIV_HI, 8'h12);
    check("div_hi_value", 32'(divisor_out), 32'h1234);
    check("div_hi_strobe", 32'(divisor_wr), 32'h1);
    @(negedge clk);
    check("div_strobe_one_cycle", 32'(divisor_wr), 32'h0);
    check("div_hold", 32'(divisor_out), 32'h1234);
    check_read("div_lo_read_zero", ADDR_DIV_LO, 8'h00);
    check_read("div_hi_read_zero", ADDR_DIV_HI, 8'h00);

    // Two characters with the transmitter idle: latency and order.
    tx_ready = 1'b1;
    @(negedge clk);
    base = tx_cnt;
    bus_write(ADDR_DATA, 8'h41);
    check("tx_lat_cycle1", 32'(tx_start), 32'h0);
    bus_write(ADDR_DATA, 8'h42);
    check("tx_lat_cycle2", 32'(tx_start), 32'h0);
    @(negedge clk);
    check("tx_lat_strobe", 32'(tx_start), 32'h1);
    check("tx_lat_data", 32'(tx_data), 32'h41);
    repeat (15) @(negedge clk);
    check("tx_two_launches", 32'(tx_cnt - base), 32'd2);
    check("tx_order_first", 32'(tx_log[base[5:0]]), 32'h41);
    check("tx_order_second", 32'(tx_log[6'(base + 1)]), 32'h42);
    check("tx_data_held", 32'(tx_data), 32'h42);
    check_read("tx_idle_status", ADDR_STATUS, 8'h09);

    // Five writes while the transmitter is busy: the fifth is dropped.
    tx_ready = 1'b0;
    base = tx_cnt;
    for (int i = 0; i < 5; i++) bus_write(ADDR_DATA, 8'(8'h50 + i));
    check_read("tx_full_status", ADDR_STATUS, 8'h00);
    repeat (5) @(negedge clk);
    check("tx_no_launch_blocked", 32'(tx_cnt - base), 32'd0);
    tx_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("tx_four_launches", 32'(tx_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("tx_drain_data", 32'(tx_log[6'(base + i)]), 32'(8'h50 + i));
    check_read("tx_drained_status", ADDR_STATUS, 8'h09);

    // RX overrun on the fifth character; reads drain in order then return 0.
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    #1 check("rd_zero_no_cs", 32'(bus.databus_out), 32'h00);
    check_read("rx_overrun_status", ADDR_STATUS, 8'h0F);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = ADDR_DIV_LO; bus.databus_in = 8'h34;
    #1 check("rd_zero_on_write", 32'(bus.databus_out), 32'h00);
    @(negedge clk);
    bus.iocs = 1'b0;
    for (int i = 1; i <= 4; i++) check_read("rx_read_order", ADDR_DATA, 8'(i));
    check_read("rx_read_empty", ADDR_DATA, 8'h00);
    check_read("rx_overrun_sticky", ADDR_STATUS, 8'h0D);
    bus_write(ADDR_STATUS, 8'h00);
    check_read("rx_overrun_cleared", ADDR_STATUS, 8'h09);

    // Full RX with a coincident push and pop: no overrun, head advances.
    for (int i = 0; i < 4; i++) rx_push(8'(8'h11 + i));
    rx_valid = 1'b1; rx_data = 8'h15;
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = ADDR_DATA;
    #1 d = bus.databus_out;
    check("rx_full_pushpop_head", 32'(d), 32'h11);
    @(negedge clk);
    rx_valid = 1'b0; bus.iocs = 1'b0; bus.iorw = 1'b0;
    check_read("rx_full_pushpop_status", ADDR_STATUS, 8'h0B);
    for (int i = 0; i < 4; i++) check_read("rx_pushpop_order", ADDR_DATA, 8'(8'h12 + i));
    check_read("rx_pushpop_empty", ADDR_DATA, 8'h00);

    // Overrun set beats a coincident status-write clear.
    for (int i = 0; i < 4; i++) rx_push(8'(8'h21 + i));
    rx_valid = 1'b1; rx_data = 8'h25;
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = ADDR_STATUS;
    @(negedge clk);
    rx_valid = 1'b0; bus.iocs = 1'b0;
    check_read("ovr_set_wins", ADDR_STATUS, 8'h0F);
    bus_write(ADDR_STATUS, 8'h00);
    check_read("ovr_clear", ADDR_STATUS, 8'h0B);
    for (int i = 0; i < 4; i++) check_read("ovr_drain", ADDR_DATA, 8'(8'h21 + i));

    // Reset while the FSM sits in LAUNCH: no strobe is ever produced.
    base = tx_cnt;
    bus_write(ADDR_DATA, 8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_launch_tx_start", 32'(tx_start), 32'h0);
    check("rst_launch_tx_data", 32'(tx_data), 32'h00);
    check("rst_launch_divisor", 32'(divisor_out), 32'h00A5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_launch_no_strobe", 32'(tx_cnt - base), 32'd0);
    check_read("rst_launch_status", ADDR_STATUS, 8'h09);

    // Reset while tx_start is high: strobe drops at once, queued data is lost.
    base = tx_cnt;
    bus_write(ADDR_DATA, 8'h78);
    bus_write(ADDR_DATA, 8'h79);
    @(negedge clk);
    check("rst_strobe_high", 32'(tx_start), 32'h1);
    check("rst_strobe_data", 32'(tx_data), 32'h78);
    rst_n = 1'b0;
    #1 check("rst_strobe_falls", 32'(tx_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_fifo_discarded", 32'(tx_cnt - base), 32'd1);
    check_read("rst_final_status", ADDR_STATUS, 8'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
